// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches a two-byte instruction (low byte first) over a
// byte-wide memory port, pulses the decoder, starts execution, optionally
// applies a taken branch, and waits for multi-cycle ops to finish.
// Optional feature: define BUS_TIMEOUT_EN to add a wait-cycle watchdog that
// forces FAULT after TIMEOUT_CYCLES stalled cycles.
// Group codes come from cpu_data.v when it is compiled first; the fallbacks
// below are used otherwise.

`ifndef GROUP_BRANCH_JUMPS
`define GROUP_BRANCH_JUMPS 4'h4
`endif
`ifndef GROUP_WRONG
`define GROUP_WRONG 4'hF
`endif

module fetch_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir,
    output logic        decoder_latch,
    input  logic [3:0]  operator_group,
    input  logic        reset_cycle,
    input  logic [8:0]  pc_branch_jump,
    input  logic        branch_taken,
    output logic        exec_start,
    input  logic        exec_done,
    output logic [15:0] pc,
    output logic        fault
);

    typedef enum logic [2:0] {
        FETCH_LO  = 3'd0,
        FETCH_HI  = 3'd1,
        DECODE    = 3'd2,
        EXEC      = 3'd3,
        WAIT_EXEC = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_run;          // low for the first cycle after reset release
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic        w_group_wrong;
    logic        w_take_branch;
    logic [15:0] w_branch_offset;

    assign w_group_wrong   = (operator_group == `GROUP_WRONG);
    assign w_take_branch   = (r_state == EXEC) && !w_group_wrong &&
                             (operator_group == `GROUP_BRANCH_JUMPS) && branch_taken;
    assign w_branch_offset = {{7{pc_branch_jump[8]}}, pc_branch_jump};

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign ir       = r_ir;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       w_waiting;

    // A stalled cycle: a request without ack, or a multi-cycle op not yet done.
    assign w_waiting = (mem_req && !mem_ack) || ((r_state == WAIT_EXEC) && !exec_done);

    // Wait counter: cleared on every state change, counts stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    // State register plus the one-cycle start-up delay after reset release.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= FETCH_LO;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
        end
    end

    // Next-state decode and Moore-style control outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state  = r_state;
        mem_req       = 1'b0;
        decoder_latch = 1'b0;
        exec_start    = 1'b0;
        fault         = 1'b0;
        case (r_state)
            FETCH_LO: begin
                mem_req = r_run;
                if (r_run && mem_ack) w_next_state = FETCH_HI;
            end
            FETCH_HI: begin
                mem_req = 1'b1;
                if (mem_ack) w_next_state = DECODE;
            end
            DECODE: begin
                decoder_latch = 1'b1;
                w_next_state  = EXEC;
            end
            EXEC: begin
                if (w_group_wrong) begin
                    w_next_state = FAULT;
                end else begin
                    exec_start   = 1'b1;
                    w_next_state = reset_cycle ? FETCH_LO : WAIT_EXEC;
                end
            end
            WAIT_EXEC: begin
                if (exec_done) w_next_state = FETCH_LO;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: w_next_state = FAULT;
        endcase
`ifdef BUS_TIMEOUT_EN
        if (w_waiting && (({1'b0, r_wait_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES)))
            w_next_state = FAULT;
`endif
    end

    // Program counter and instruction register datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ir <= 16'h0000;
        end else if (mem_req && mem_ack) begin
            if (r_state == FETCH_LO) r_ir[7:0]  <= mem_rdata;
            else                     r_ir[15:8] <= mem_rdata;
            r_pc <= r_pc + 16'd1;
        end else if (w_take_branch) begin
            r_pc <= r_pc + w_branch_offset;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset state, zero-wait fetch timing,
// PC wrap, taken/not-taken branch, multi-cycle wait, reset mid-fetch,
// GROUP_WRONG fault and the stalled-bus behaviour (with or without
// BUS_TIMEOUT_EN).

`ifndef GROUP_BRANCH_JUMPS
`define GROUP_BRANCH_JUMPS 4'h4
`endif
`ifndef GROUP_WRONG
`define GROUP_WRONG 4'hF
`endif

module tb_fetch_sequencer;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    logic [7:0] mem [0:255];

    // Main DUT (RESET_PC = 0)
    logic        mem_req, mem_ack, decoder_latch, exec_start, fault;
    logic [15:0] mem_addr, ir, pc;
    logic [7:0]  mem_rdata;
    logic [3:0]  operator_group;
    logic        reset_cycle, branch_taken, exec_done, ack_en;
    logic [8:0]  pc_branch_jump;

    // Second DUT (RESET_PC = FFFF, TIMEOUT_CYCLES = 4)
    logic        mem_req2, mem_ack2, decoder_latch2, exec_start2, fault2;
    logic [15:0] mem_addr2, ir2, pc2;
    logic [7:0]  mem_rdata2;
    logic [3:0]  operator_group2;
    logic        reset_cycle2, branch_taken2, exec_done2, ack_en2;
    logic [8:0]  pc_branch_jump2;

    // Zero-wait memory: ack in the same cycle as the request.
    assign mem_rdata  = mem[mem_addr[7:0]];
    assign mem_ack    = mem_req & ack_en;
    assign mem_rdata2 = mem[mem_addr2[7:0]];
    assign mem_ack2   = mem_req2 & ack_en2;

    fetch_sequencer #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir),
        .decoder_latch(decoder_latch), .operator_group(operator_group),
        .reset_cycle(reset_cycle), .pc_branch_jump(pc_branch_jump),
        .branch_taken(branch_taken), .exec_start(exec_start),
        .exec_done(exec_done), .pc(pc), .fault(fault)
    );

    fetch_sequencer #(.RESET_PC(16'hFFFF), .TIMEOUT_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .ir(ir2),
        .decoder_latch(decoder_latch2), .operator_group(operator_group2),
        .reset_cycle(reset_cycle2), .pc_branch_jump(pc_branch_jump2),
        .branch_taken(branch_taken2), .exec_start(exec_start2),
        .exec_done(exec_done2), .pc(pc2), .fault(fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        ack_en          = 1'b1;
        operator_group  = 4'h0;
        reset_cycle     = 1'b1;
        pc_branch_jump  = 9'h000;
        branch_taken    = 1'b0;
        exec_done       = 1'b0;
        ack_en2         = 1'b1;
        operator_group2 = 4'h0;
        reset_cycle2    = 1'b1;
        pc_branch_jump2 = 9'h000;
        branch_taken2   = 1'b0;
        exec_done2      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h10;
        mem[8'h01] = 8'h22;
        mem[8'hFF] = 8'h34;
        mem[8'h12] = 8'h5A;
        mem[8'h13] = 8'hA5;

        // Reset state
        step();
        check("rst_pc",        pc, 16'h0000);
        check("rst_ir",        ir, 16'h0000);
        check("rst_mem_req",   16'(mem_req), 16'h0);
        check("rst_latch",     16'(decoder_latch), 16'h0);
        check("rst_exec",      16'(exec_start), 16'h0);
        check("rst_fault",     16'(fault), 16'h0);
        check("rst_pc2",       pc2, 16'hFFFF);
        rst = 1'b0;

        // Zero-wait fetch of 10 22 at 0x0000
        step();
        check("c1_mem_req",    16'(mem_req), 16'h1);
        check("c1_addr",       mem_addr, 16'h0000);
        check("c1_addr2",      mem_addr2, 16'hFFFF);
        step();
        check("c2_mem_req",    16'(mem_req), 16'h1);
        check("c2_addr",       mem_addr, 16'h0001);
        check("c2_ir_lo",      ir, 16'h0010);
        check("c2_addr2_wrap", mem_addr2, 16'h0000);
        step();
        check("c3_latch",      16'(decoder_latch), 16'h1);
        check("c3_mem_req",    16'(mem_req), 16'h0);
        check("c3_ir",         ir, 16'h2210);
        check("c3_pc",         pc, 16'h0002);
        check("c3_pc2",        pc2, 16'h0001);
        check("c3_ir2",        ir2, 16'h1034);
        step();
        check("c4_exec_start", 16'(exec_start), 16'h1);
        check("c4_latch",      16'(decoder_latch), 16'h0);
        step();
        check("c5_mem_req",    16'(mem_req), 16'h1);
        check("c5_addr",       mem_addr, 16'h0002);
        check("c5_exec_start", 16'(exec_start), 16'h0);

        // Run straight-line instructions up to 0x0010
        for (int k = 0; k < 7; k++) begin
            repeat (4) step();
            check("seq_addr", mem_addr, 16'(2 + 2 * (k + 1)));
        end

        // Taken branch at 0x0010 with offset -4
        operator_group = `GROUP_BRANCH_JUMPS;
        pc_branch_jump = 9'h1FC;
        branch_taken   = 1'b1;
        repeat (3) step();
        check("br_exec_start", 16'(exec_start), 16'h1);
        step();
        check("br_taken_addr", mem_addr, 16'h000E);
        branch_taken = 1'b0;
        repeat (4) step();
        check("br_nt_addr_a",  mem_addr, 16'h0010);
        repeat (4) step();
        check("br_nt_addr_b",  mem_addr, 16'h0012);
        operator_group = 4'h0;

        // Multi-cycle op: exec_done pulsed during EXEC is ignored
        reset_cycle = 1'b0;
        repeat (3) step();
        check("mc_exec_start", 16'(exec_start), 16'h1);
        check("mc_ir",         ir, 16'hA55A);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("mc_wait_req", 16'(mem_req), 16'h0);
            if (i != 9) step();
        end
        exec_done = 1'b1;
        step();
        exec_done   = 1'b0;
        reset_cycle = 1'b1;
        check("mc_resume_req",  16'(mem_req), 16'h1);
        check("mc_resume_addr", mem_addr, 16'h0014);

        // Stall a fetch, then assert reset mid-cycle
        ack_en = 1'b0;
        repeat (2) step();
        check("stall_req",  16'(mem_req), 16'h1);
        check("stall_addr", mem_addr, 16'h0014);
        rst = 1'b1;
        #1;
        check("midrst_req",   16'(mem_req), 16'h0);
        check("midrst_ir",    ir, 16'h0000);
        check("midrst_pc",    pc, 16'h0000);
        check("midrst_fault", 16'(fault), 16'h0);

        // GROUP_WRONG on dut; stalled bus on dut2
        ack_en         = 1'b1;
        ack_en2        = 1'b0;
        operator_group = `GROUP_WRONG;
        step();
        rst = 1'b0;
        step();
        check("gw_c1_req",  16'(mem_req), 16'h1);
        check("to_c1_req2", 16'(mem_req2), 16'h1);
        check("to_c1_addr2", mem_addr2, 16'hFFFF);
        repeat (3) step();
        check("gw_exec_start", 16'(exec_start), 16'h0);
        check("gw_exec_fault", 16'(fault), 16'h0);
        step();
        check("gw_fault",   16'(fault), 16'h1);
        check("gw_mem_req", 16'(mem_req), 16'h0);
`ifdef BUS_TIMEOUT_EN
        check("to_fault2",   16'(fault2), 16'h1);
        check("to_mem_req2", 16'(mem_req2), 16'h0);
`else
        check("to_fault2",   16'(fault2), 16'h0);
        check("to_mem_req2", 16'(mem_req2), 16'h1);
`endif
        operator_group = 4'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("gw_hold_fault", 16'(fault), 16'h1);
            check("gw_hold_req",   16'(mem_req), 16'h0);
            check("gw_hold_exec",  16'(exec_start), 16'h0);
        end
`ifndef BUS_TIMEOUT_EN
        check("to_still_req2", 16'(mem_req2), 16'h1);
`endif
        rst = 1'b1;
        #1;
        check("gw_rst_fault", 16'(fault), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: wait-cycle limit, used only when BUS_TIMEOUT_EN is defined; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_req  output  1  byte-read request to program memory.
REQ-006 mem_addr  output  16  byte address of the current request.
REQ-007 mem_rdata  input  8  read data, valid when mem_ack=1.
REQ-008 mem_ack  input  1  one-cycle read completion.
REQ-009 ir  output  16  assembled instruction word: low byte from PC, high byte from PC+1.
REQ-010 decoder_latch  output  1  one-cycle pulse clocking the instruction decoder.
REQ-011 operator_group  input  4  decoder group code (`GROUP_* from cpu_data.v).
REQ-012 reset_cycle  input  1  decoder flag: 1 = single-cycle op, 0 = multi-cycle op.
REQ-013 pc_branch_jump  input  9  decoder branch offset, two's complement.
REQ-014 branch_taken  input  1  condition result from the execute unit.
REQ-015 exec_start  output  1  one-cycle pulse starting execution of the decoded op.
REQ-016 exec_done  input  1  multi-cycle op completion.
REQ-017 pc  output  16  program counter.
REQ-018 fault  output  1  sticky error flag.

Function
REQ-019 The FSM SHALL use states FETCH_LO, FETCH_HI, DECODE, EXEC, WAIT_EXEC and FAULT.
REQ-020 FETCH_LO SHALL drive mem_req=1 and mem_addr=pc; on mem_ack it SHALL load ir[7:0]=mem_rdata, set pc=pc+1 and go to FETCH_HI.
REQ-021 FETCH_HI SHALL behave as FETCH_LO but load ir[15:8], then go to DECODE.
REQ-022 pc increments SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-023 DECODE SHALL assert decoder_latch for exactly one cycle, then go to EXEC; decoder outputs are sampled only in EXEC.
REQ-024 EXEC with operator_group==`GROUP_WRONG SHALL go to FAULT without pulsing exec_start.
REQ-025 EXEC otherwise SHALL pulse exec_start for one cycle.
REQ-026 EXEC with group `GROUP_BRANCH_JUMPS and branch_taken=1 SHALL set pc = pc + sign_extend16(pc_branch_jump), modulo 2^16; pc is already past the instruction at this point.
REQ-027 EXEC with reset_cycle=1 SHALL go to FETCH_LO next; with reset_cycle=0 it SHALL go to WAIT_EXEC.
REQ-028 WAIT_EXEC SHALL go to FETCH_LO on the first cycle exec_done=1; exec_done outside WAIT_EXEC SHALL be ignored.
REQ-029 mem_ack outside FETCH_LO/FETCH_HI SHALL be ignored; mem_req SHALL be 0 in every other state.
REQ-030 FAULT SHALL hold fault=1, mem_req=0 and exec_start=0 until reset.
REQ-031 Instruction latency with zero-wait memory and reset_cycle=1: 5 cycles (LO, HI, DECODE, EXEC, then next LO).

Reset
REQ-032 While rst=1: state=FETCH_LO, pc=RESET_PC, ir=16'h0000, fault=0, and decoder_latch, exec_start, mem_req all 0 (mem_req rises on the first clock after release).
REQ-033 Reset asserted mid-fetch or mid-WAIT_EXEC SHALL abandon the operation immediately with no partial ir update.

Configuration
REQ-034 With BUS_TIMEOUT_EN defined:
- A wait counter SHALL clear on every state change.
- It SHALL increment each cycle spent in FETCH_LO, FETCH_HI or WAIT_EXEC without mem_ack or exec_done respectively.
- Reaching TIMEOUT_CYCLES SHALL force FAULT.
REQ-035 Without BUS_TIMEOUT_EN there is no counter; waits are unbounded and FAULT is entered only via `GROUP_WRONG.

Verification
REQ-036 Zero-wait memory holding bytes 8'h10, 8'h22 at 0x0000 with reset_cycle=1 -> ir=16'h2210, decoder_latch pulses in cycle 3, exec_start in cycle 4, pc=0x0002, mem_addr=0x0002 in cycle 5.
REQ-037 Branch at 0x0010, group `GROUP_BRANCH_JUMPS, pc_branch_jump=9'h1FC (-4), branch_taken=1 -> next fetch address 0x000E; with branch_taken=0 -> 0x0012.
REQ-038 RESET_PC=16'hFFFF -> fetches at 0xFFFF then 0x0000, pc=0x0001 after the fetch.
REQ-039 reset_cycle=0 with exec_done held low 10 cycles, then high -> no mem_req during the wait, FETCH_LO on the cycle after exec_done.
REQ-040 operator_group=`GROUP_WRONG -> fault=1 and stays 1, no exec_start, mem_req=0 until rst.
REQ-041 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> fault=1 after 4 request cycles; without the macro, mem_req stays 1 indefinitely.
